// File: rtl/datamem_port_arbiter.sv
// Data-memory port arbiter with a built-in block-copy engine.
// The CPU load/store path always owns the memory ports. The copy engine
// moves one byte per read/write pair and only uses a port in a cycle where
// the CPU leaves that port idle.
module datamem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // CPU load/store path
  input  logic              i_cpu_rd_req,
  input  logic [ADDR_W-1:0] i_cpu_rd_addr,
  output logic [DATA_W-1:0] o_cpu_rd_data,
  input  logic              i_cpu_wr_req,
  input  logic [ADDR_W-1:0] i_cpu_wr_addr,
  input  logic [DATA_W-1:0] i_cpu_wr_data,
  // copy engine control
  input  logic              i_dma_start,
  input  logic              i_dma_abort,
  input  logic [ADDR_W-1:0] i_dma_src,
  input  logic [ADDR_W-1:0] i_dma_dst,
  input  logic [LEN_W-1:0]  i_dma_len,
  output logic              o_dma_busy,
  output logic              o_dma_done,
  // data memory side
  output logic [ADDR_W-1:0] o_data_rd_addr,
  input  logic [DATA_W-1:0] i_datamem_rd_data,
  output logic [ADDR_W-1:0] o_data_wr_addr,
  output logic [DATA_W-1:0] o_datamem_wr_data,
  output logic              o_store_to_mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src_ptr;
  logic [ADDR_W-1:0]   r_dst_ptr;
  logic [LEN_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_buf;
  logic                r_dma_busy;
  logic                r_dma_done;

  // The engine only gets a port in a cycle where the CPU is not using it.
  logic w_dma_rd;
  logic w_dma_wr;

  assign w_dma_rd = (r_state == ST_RD) && !i_cpu_rd_req;
  assign w_dma_wr = (r_state == ST_WR) && !i_cpu_wr_req;

  // Copy sequencer: busy/done are registered alongside the state so they
  // always reflect the state the FSM is currently in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_buf       <= '0;
      r_dma_busy  <= 1'b0;
      r_dma_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_dma_start) begin
            r_src_ptr   <= i_dma_src;
            r_dst_ptr   <= i_dma_dst;
            r_remaining <= i_dma_len;
            if (i_dma_len == '0) begin
              r_state    <= ST_DONE;
              r_dma_done <= 1'b1;
            end else begin
              r_state    <= ST_RD;
              r_dma_busy <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (i_dma_abort) begin
            r_state    <= ST_IDLE;
            r_dma_busy <= 1'b0;
          end else if (w_dma_rd) begin
            r_buf     <= i_datamem_rd_data;
            r_src_ptr <= r_src_ptr + 1'b1;
            r_state   <= ST_WR;
          end
        end
        ST_WR: begin
          if (i_dma_abort) begin
            r_state    <= ST_IDLE;
            r_dma_busy <= 1'b0;
          end else if (w_dma_wr) begin
            r_dst_ptr   <= r_dst_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LEN_W'(1)) begin
              r_state    <= ST_DONE;
              r_dma_busy <= 1'b0;
              r_dma_done <= 1'b1;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_dma_done <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_dma_busy <= 1'b0;
          r_dma_done <= 1'b0;
        end
      endcase
    end
  end

  // Port muxing: the CPU address/data are the default on both ports.
  assign o_data_rd_addr    = w_dma_rd ? r_src_ptr : i_cpu_rd_addr;
  assign o_cpu_rd_data     = i_datamem_rd_data;
  assign o_data_wr_addr    = w_dma_wr ? r_dst_ptr : i_cpu_wr_addr;
  assign o_datamem_wr_data = w_dma_wr ? r_buf : i_cpu_wr_data;
  // Write enable is gated by reset so no store can slip out while rst_n is low.
  assign o_store_to_mem    = i_rst_n & (w_dma_wr | i_cpu_wr_req);

  assign o_dma_busy = r_dma_busy;
  assign o_dma_done = r_dma_done;

endmodule

// File: doc/datamem_port_arbiter.md
Name: datamem_port_arbiter

Overview:
- Shares the single data-memory read address and write port between the CPU load/store path and a built-in block-copy (DMA) engine.
- The CPU always has priority. The DMA copies `len` bytes from `src` to `dst` inside data memory, using only the cycles in which the CPU leaves a port idle.
- Sits between the core datapath and the instruction/data memory. It drives that memory's `data_rd_addr`, `data_wr_addr`, `datamem_wr_data` and `store_to_mem`.

Parameters:
- ADDR_W, 8, data-memory address width; pointers wrap modulo 2^ADDR_W.
- DATA_W, 8, data word width.
- LEN_W, 9, copy-length width; allows 0..256 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd_req  in  1  CPU load this cycle.
- cpu_rd_addr  in  ADDR_W  CPU load address.
- cpu_rd_data  out  DATA_W  load data; combinational copy of datamem_rd_data.
- cpu_wr_req  in  1  CPU store this cycle.
- cpu_wr_addr  in  ADDR_W  CPU store address.
- cpu_wr_data  in  DATA_W  CPU store data.
- dma_start  in  1  one-cycle start pulse; sampled only in IDLE.
- dma_abort  in  1  abort the active copy.
- dma_src  in  ADDR_W  source base; latched on start.
- dma_dst  in  ADDR_W  destination base; latched on start.
- dma_len  in  LEN_W  byte count; latched on start.
- dma_busy  out  1  high in RD and WR states.
- dma_done  out  1  one-cycle completion pulse.
- data_rd_addr  out  ADDR_W  to memory read address.
- datamem_rd_data  in  DATA_W  from memory; combinational read.
- data_wr_addr  out  ADDR_W  to memory write address.
- datamem_wr_data  out  DATA_W  to memory write data.
- store_to_mem  out  1  to memory write enable.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; src_ptr, dst_ptr, remaining and buf are all cleared to 0.
  - dma_busy=0, dma_done=0.
  - store_to_mem is forced 0 combinationally while rst_n=0.
  - Reset mid-copy abandons the copy; no done pulse is issued.
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: on dma_start=1, latch src, dst and len.
    - len=0 goes to DONE.
    - Otherwise goes to RD.
  - RD, cpu_rd_req=0: data_rd_addr=src_ptr. At the clock edge, buf<=datamem_rd_data, src_ptr+=1, then go to WR.
  - RD, cpu_rd_req=1: stall in RD; the CPU owns the read port.
  - WR, cpu_wr_req=0: store_to_mem=1, data_wr_addr=dst_ptr, datamem_wr_data=buf. At the clock edge, dst_ptr+=1 and remaining-=1.
    - remaining was 1: go to DONE.
    - Otherwise: go to RD.
  - WR, cpu_wr_req=1: stall in WR; the CPU store proceeds.
  - DONE: dma_done=1 for exactly one cycle, then go to IDLE.
- Port muxing (combinational):
  - Read port: data_rd_addr=src_ptr only when in RD and cpu_rd_req=0; otherwise cpu_rd_addr.
  - Write port: DMA write fields apply when in WR and cpu_wr_req=0. Otherwise data_wr_addr=cpu_wr_addr, datamem_wr_data=cpu_wr_data, store_to_mem=cpu_wr_req.
- Throughput and latency:
  - Minimum 2 cycles per byte.
  - With no contention, dma_done rises 2*len+1 cycles after the start edge.
- dma_start in any state other than IDLE is ignored.
- dma_abort in RD or WR: go to IDLE at the next edge with no done pulse. Bytes already written remain in memory. Abort is ignored in IDLE and DONE.
- Pointer increments wrap: 8'hFF+1 = 8'h00.
- Overlapping src/dst ranges are copied forward, byte by byte; there is no overlap protection.
- CPU store and DMA read in the same cycle to the same address: the DMA reads the pre-store value, because the write commits at the edge.

Test Plan:
- Reset/idle: hold rst_n=0 with cpu_wr_req=1 -> store_to_mem=0, dma_busy=0, dma_done=0. Release reset; CPU read at 0x10 -> data_rd_addr=0x10 and cpu_rd_data equals mem[0x10] in the same cycle.
- Uncontended copy: mem[0x20..0x23]=AA,BB,CC,DD; start src=0x20, dst=0x80, len=4 -> four writes on alternate cycles; dma_done 9 cycles after start; mem[0x80..0x83]=AA,BB,CC,DD.
- Contention: same copy with cpu_rd_req held for 3 cycles during RD and cpu_wr_req held for 2 cycles during WR -> DMA stalls 5 extra cycles; CPU accesses unaffected; done at cycle 14; copied data correct.
- Wrap and len boundaries:
  - src=0xFE, dst=0x01, len=3 -> reads 0xFE, 0xFF, 0x00.
  - len=0 -> done 1 cycle after start, no store_to_mem.
  - len=256 -> all 256 bytes copied.
- Abort/restart: abort after 2 of 5 bytes -> exactly 2 bytes written, no dma_done, back to IDLE. dma_start while busy -> ignored; latched len unchanged.
- Reset mid-copy: drop rst_n during WR -> store_to_mem falls immediately; after release, the FSM is in IDLE and a new start runs normally.
